cam_capture: RTL and testbench

- Upstream neighbour of the frame-buffer write path. Samples the OV7670 parallel byte stream (d[7:0], href, vsync), pairs RGB444 bytes into 12-bit pixels and emits an i_valid/i_data-style stream.
- Each frame produces exactly H_ACTIVE*V_ACTIVE valid pixels, so the downstream BRAM write address (wrap at H_ACTIVE*V_ACTIVE-1) stays frame-aligned.
- Malformed lines and frames are flagged. Output pixels never exceed the active area.

---
 rtl/cam_pkg.sv | 38 +++
 rtl/cam_byte_packer.sv | 40 ++++
 rtl/cam_capture.sv | 169 ++++++++++++++++
 tb/tb_cam_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cam_pkg : shared FSM encodings, RGB444 field map and byte phases       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package cam_pkg;

  typedef enum logic [1:0] {
    S_WAIT_CFG = 2'd0,
    S_SKIP     = 2'd1,
    S_WAIT_VS  = 2'd2,
    S_ACTIVE   = 2'd3
  } cam_state_e;

  localparam int c_PIX_W = 12;
  localparam int c_R_MSB = 11;
  localparam int c_R_LSB = 8;
  localparam int c_G_MSB = 7;
  localparam int c_G_LSB = 4;
  localparam int c_B_MSB = 3;
  localparam int c_B_LSB = 0;

  localparam logic c_PHASE_BYTE0 = 1'b0;
  localparam logic c_PHASE_BYTE1 = 1'b1;

  // First byte carries R in its low nibble; second byte carries {G,B}.
  function automatic logic [c_PIX_W-1:0] pack_rgb444(input logic [3:0] red,
                                                     input logic [7:0] green_blue);
    logic [c_PIX_W-1:0] pix;
    pix                  = '0;
    pix[c_R_MSB:c_R_LSB] = red;
    pix[c_G_MSB:c_G_LSB] = green_blue[7:4];
    pix[c_B_MSB:c_B_LSB] = green_blue[3:0];
    return pix;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_byte_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cam_byte_packer : pairs href-qualified bytes into RGB444 pixels        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_en,
  input  logic               i_href,
  input  logic [7:0]         i_data,
  output logic               o_pix_valid,
  output logic [c_PIX_W-1:0] o_pix,
  output logic               o_odd_byte
);

  logic       r_phase;
  logic [3:0] r_byte0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_phase <= c_PHASE_BYTE0;
      r_byte0 <= '0;
    end else if (!i_en || !i_href) begin
      r_phase <= c_PHASE_BYTE0;
    end else begin
      if (r_phase == c_PHASE_BYTE0) r_byte0 <= i_data[3:0];
      r_phase <= ~r_phase;
    end
  end

  assign o_pix_valid = i_en & i_href & (r_phase == c_PHASE_BYTE1);
  assign o_pix       = pack_rgb444(r_byte0, i_data);
  // Phase still pointing at byte1 once href has dropped means a dangling byte.
  assign o_odd_byte  = ~i_href & (r_phase == c_PHASE_BYTE1);

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cam_capture : OV7670 byte stream to frame-aligned RGB444 pixel stream  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module cam_capture
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cfg_done,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [7:0]            i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_frame_done,
  output logic                  o_frame_err
);

  localparam int c_COL_W  = $clog2(H_ACTIVE + 1);
  localparam int c_ROW_W  = $clog2(V_ACTIVE + 1);
  localparam int c_SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [c_COL_W-1:0]  c_H_MAX     = c_COL_W'(H_ACTIVE);
  localparam logic [c_COL_W-1:0]  c_H_LAST    = c_COL_W'(H_ACTIVE - 1);
  localparam logic [c_ROW_W-1:0]  c_V_MAX     = c_ROW_W'(V_ACTIVE);
  localparam logic [c_SKIP_W-1:0] c_SKIP_LAST =
    c_SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  logic                r_vsync, r_vsync_d, r_href, r_href_d;
  logic [7:0]          r_data;
  cam_state_e          r_state;
  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [c_SKIP_W-1:0] r_skip;
  logic                r_line_err;

  logic               w_vs_fall, w_vs_rise, w_href_fall;
  logic               w_en, w_pix_valid, w_pix_ok, w_odd_byte, w_line_err_now;
  logic [c_PIX_W-1:0] w_pix;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_data    <= '0;
    end else begin
      r_vsync   <= i_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= i_href;
      r_href_d  <= r_href;
      r_data    <= i_data;
    end
  end

  assign w_vs_fall   = r_vsync_d & ~r_vsync;
  assign w_vs_rise   = ~r_vsync_d & r_vsync;
  assign w_href_fall = r_href_d & ~r_href;
  assign w_en        = (r_state == S_ACTIVE) & i_cfg_done;

  cam_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_en        (w_en),
    .i_href      (r_href),
    .i_data      (r_data),
    .o_pix_valid (w_pix_valid),
    .o_pix       (w_pix),
    .o_odd_byte  (w_odd_byte)
  );

  assign w_pix_ok = w_pix_valid & (r_col < c_H_MAX) & (r_row < c_V_MAX);

  // Counters saturate at the active size, so overruns are caught as they happen.
  assign w_line_err_now =
      (w_href_fall & ((r_col != c_H_MAX) | w_odd_byte | (r_row == c_V_MAX)))
    | (w_pix_valid & (r_col == c_H_MAX))
    | (w_vs_rise & r_href);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= S_WAIT_CFG;
      r_col        <= '0;
      r_row        <= '0;
      r_skip       <= '0;
      r_line_err   <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_eol        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (!i_cfg_done) begin
        r_state    <= S_WAIT_CFG;
        r_col      <= '0;
        r_row      <= '0;
        r_skip     <= '0;
        r_line_err <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT_CFG: begin
            r_skip  <= '0;
            r_state <= (SKIP_FRAMES > 0) ? S_SKIP : S_WAIT_VS;
          end
          S_SKIP: begin
            if (w_vs_fall) begin
              if (r_skip == c_SKIP_LAST) r_state <= S_WAIT_VS;
              else                       r_skip  <= r_skip + 1'b1;
            end
          end
          S_WAIT_VS: begin
            if (w_vs_fall) begin
              r_state    <= S_ACTIVE;
              r_col      <= '0;
              r_row      <= '0;
              r_line_err <= 1'b0;
            end
          end
          S_ACTIVE: begin
            if (w_pix_ok) begin
              o_valid <= 1'b1;
              o_data  <= DATA_WIDTH'(w_pix);
              o_sof   <= (r_row == '0) && (r_col == '0);
              o_eol   <= (r_col == c_H_LAST);
            end
            if (w_pix_valid && (r_col != c_H_MAX)) r_col <= r_col + 1'b1;
            if (w_href_fall) begin
              r_col <= '0;
              if (r_row != c_V_MAX) r_row <= r_row + 1'b1;
            end
            if (w_line_err_now) r_line_err <= 1'b1;
            if (w_vs_rise) begin
              o_frame_done <= 1'b1;
              o_frame_err  <= r_line_err | w_line_err_now | (r_row != c_V_MAX);
              r_line_err   <= 1'b0;
              r_state      <= S_WAIT_VS;
            end else if (w_vs_fall) begin
              // Missing vs_rise: close the broken frame and restart in place.
              o_frame_done <= 1'b1;
              o_frame_err  <= 1'b1;
              r_line_err   <= 1'b0;
              r_col        <= '0;
              r_row        <= '0;
            end
          end
          default: r_state <= S_WAIT_CFG;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cam_capture : directed bench for cam_capture (4x3 frame, skip 1)   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_cam_capture;

  logic        clk = 1'b0;
  logic        rstn, cfg_done, vsync, href;
  logic [7:0]  data;
  logic        valid, sof, eol, frame_done, frame_err;
  logic [11:0] pix;

  cam_capture #(
    .DATA_WIDTH  (12),
    .H_ACTIVE    (4),
    .V_ACTIVE    (3),
    .SKIP_FRAMES (1)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_cfg_done   (cfg_done),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_data       (data),
    .o_valid      (valid),
    .o_data       (pix),
    .o_sof        (sof),
    .o_eol        (eol),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          nv, fd, fd_err, bad_data, stray, first_cyc, t_b1;
  logic [31:0] sof_mask, eol_mask;
  logic [11:0] data4, exp_pix;
  logic [7:0]  b0, b1;
  bit          probe = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (valid) begin
      if (nv < 32) begin
        sof_mask[nv] = sof;
        eol_mask[nv] = eol;
      end
      if (pix != exp_pix) bad_data++;
      if (nv == 0) first_cyc = cyc;
      if (nv == 4) data4 = pix;
      nv++;
    end else if (sof || eol) begin
      stray++;
    end
    if (frame_done) begin
      fd++;
      fd_err = int'(frame_err);
    end else if (frame_err) begin
      stray++;
    end
  end

  task automatic clear_stats();
    nv = 0; fd = 0; fd_err = -1; bad_data = 0; stray = 0;
    first_cyc = -1; sof_mask = '0; eol_mask = '0; data4 = '0;
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      data = (i % 2 == 0) ? b0 : b1;
      if (probe && i == 1) begin
        t_b1  = cyc;
        probe = 0;
      end
      @(negedge clk);
    end
    href = 1'b0;
    data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int sp_row, input int sp_bytes);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < nlines; r++) send_line((r == sp_row) ? sp_bytes : 8);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
    b0 = 8'h0A; b1 = 8'h5C; exp_pix = 12'hA5C; t_b1 = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_valid", int'(valid), 0);
    check("reset_done", int'(frame_done), 0);

    // Bring up and reach capture, then pull reset in the middle of a line.
    rstn = 1'b1; cfg_done = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(3, -1, 0);
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    href = 1'b1; data = b0; @(negedge clk);
    data = b1; @(negedge clk);
    data = b0;
    @(posedge clk); #2;
    check("pre_reset_valid", int'(valid), 1);
    rstn = 1'b0;
    #1;
    check("async_rst_outs", int'({valid, sof, eol, frame_done, frame_err}), 0);
    check("async_rst_data", int'(pix), 0);
    @(negedge clk);
    href = 1'b0; vsync = 1'b0; data = 8'h00;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // First frame after reset is discarded.
    clear_stats();
    send_frame(3, -1, 0);
    check("skip_valid_cnt", nv, 0);
    check("skip_done_cnt", fd, 0);

    // Nominal frame.
    clear_stats(); probe = 1;
    send_frame(3, -1, 0);
    check("nom_valid_cnt", nv, 12);
    check("nom_bad_data", bad_data, 0);
    check("nom_sof_mask", int'(sof_mask), 'h1);
    check("nom_eol_mask", int'(eol_mask), 'h888);
    check("nom_latency", first_cyc - t_b1, 2);
    check("nom_done_cnt", fd, 1);
    check("nom_frame_err", fd_err, 0);
    check("nom_stray", stray, 0);

    // Different pixel content to exercise every nibble position.
    b0 = 8'hF3; b1 = 8'h96; exp_pix = 12'h396;
    clear_stats();
    send_frame(3, -1, 0);
    check("pat2_valid_cnt", nv, 12);
    check("pat2_bad_data", bad_data, 0);
    check("pat2_frame_err", fd_err, 0);
    b0 = 8'h0A; b1 = 8'h5C; exp_pix = 12'hA5C;

    // Long line: row 1 carries 6 pixels.
    clear_stats();
    send_frame(3, 1, 12);
    check("long_valid_cnt", nv, 12);
    check("long_eol_mask", int'(eol_mask), 'h888);
    check("long_frame_err", fd_err, 1);
    clear_stats();
    send_frame(3, -1, 0);
    check("after_long_err", fd_err, 0);
    check("after_long_cnt", nv, 12);

    // Odd byte count in row 0.
    clear_stats();
    send_frame(3, 0, 9);
    check("odd_valid_cnt", nv, 12);
    check("odd_pix4", int'(data4), 'hA5C);
    check("odd_bad_data", bad_data, 0);
    check("odd_frame_err", fd_err, 1);

    // Short frame: two lines only.
    clear_stats();
    send_frame(2, -1, 0);
    check("short_valid_cnt", nv, 8);
    check("short_done_cnt", fd, 1);
    check("short_frame_err", fd_err, 1);

    // Configuration dropped during the second line.
    clear_stats();
    vsync = 1'b1; repeat (4) @(negedge clk);
    vsync = 1'b0; repeat (3) @(negedge clk);
    send_line(8);
    href = 1'b1; data = b0; @(negedge clk);
    data = b1; cfg_done = 1'b0; @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      data = (i % 2 == 0) ? b0 : b1;
      @(negedge clk);
    end
    href = 1'b0; repeat (4) @(negedge clk);
    send_line(8);
    vsync = 1'b1; repeat (4) @(negedge clk);
    check("cfgdrop_valid_cnt", nv, 4);
    check("cfgdrop_done_cnt", fd, 0);
    cfg_done = 1'b1;
    repeat (2) @(negedge clk);
    clear_stats();
    send_frame(3, -1, 0);
    check("recfg_skip_cnt", nv, 0);
    clear_stats();
    send_frame(3, -1, 0);
    check("recfg_valid_cnt", nv, 12);
    check("recfg_sof_mask", int'(sof_mask), 'h1);
    check("recfg_frame_err", fd_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
